// File: rtl/sm_arbiter.sv
// sm_arbiter: round-robin arbiter that lets NUM_CORES cores share one
// single-ported memory, one transaction at a time.  Each grant latches the
// winning core's request, issues a one-cycle memory strobe, returns load data
// with a one-cycle completion pulse, then waits for the core to drop its
// request so that a held request is never served twice.
module sm_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_we,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [DATA_W-1:0]             core_rdata,
    output logic [NUM_CORES-1:0]          core_val_data,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy,
    output logic [2:0]                    grant_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t                 state_q;
    logic [2:0]             rr_ptr_q;
    logic [2:0]             grant_q;
    logic                   mem_en_q;
    logic                   mem_we_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [DATA_W-1:0]      mem_wdata_q;
    logic [DATA_W-1:0]      core_rdata_q;
    logic [NUM_CORES-1:0]   val_q;
    logic                   busy_q;

    logic                   found_d;
    logic [2:0]             sel_idx_d;
    logic                   sel_we_d;
    logic [ADDR_W-1:0]      sel_addr_d;
    logic [DATA_W-1:0]      sel_wdata_d;
    logic [NUM_CORES-1:0]   gnt_oh_d;
    logic                   gnt_req_d;
    logic [2:0]             rr_ptr_d;

    // Pick the first requester at or above rr_ptr; if none, wrap to the lowest requester.
    always_comb begin
        found_d     = 1'b0;
        sel_idx_d   = '0;
        sel_we_d    = 1'b0;
        sel_addr_d  = '0;
        sel_wdata_d = '0;
        // Two ordered passes replace a modulo-rotated search so every
        // vector select uses a loop constant rather than a computed index.
        for (int unsigned j = 0; j < NUM_CORES; j++) begin
            if (!found_d && core_req[j] && (j >= 32'(rr_ptr_q))) begin
                found_d     = 1'b1;
                sel_idx_d   = 3'(j);
                sel_we_d    = core_we[j];
                sel_addr_d  = core_addr[j*ADDR_W +: ADDR_W];
                sel_wdata_d = core_wdata[j*DATA_W +: DATA_W];
            end
        end
        for (int unsigned j = 0; j < NUM_CORES; j++) begin
            if (!found_d && core_req[j]) begin
                found_d     = 1'b1;
                sel_idx_d   = 3'(j);
                sel_we_d    = core_we[j];
                sel_addr_d  = core_addr[j*ADDR_W +: ADDR_W];
                sel_wdata_d = core_wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // Decode the granted core to one-hot, its live request, and the next rr_ptr.
    always_comb begin
        gnt_oh_d = '0;
        for (int unsigned j = 0; j < NUM_CORES; j++) begin
            gnt_oh_d[j] = (32'(grant_q) == j);
        end
        gnt_req_d = |(core_req & gnt_oh_d);
        rr_ptr_d  = (grant_q == 3'(NUM_CORES - 1)) ? '0 : grant_q + 3'd1;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rdata_q <= '0;
            val_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            mem_en_q <= 1'b0;
            val_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        state_q     <= S_ISSUE;
                        grant_q     <= sel_idx_d;
                        mem_we_q    <= sel_we_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        mem_en_q    <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (!mem_we_q) begin
                        core_rdata_q <= mem_rdata;
                    end
                    val_q    <= gnt_oh_d;
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!gnt_req_d) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign core_rdata    = core_rdata_q;
    assign core_val_data = val_q;
    assign mem_en        = mem_en_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign busy          = busy_q;
    assign grant_id      = grant_q;

endmodule

// File: doc/sm_arbiter.md
SM_ARBITER -- requirements
Module: sm_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4: number of GPU cores sharing one shared-memory port (2..8).
REQ-002 Parameter ADDR_W, default 12: shared-memory address width.
REQ-003 Parameter DATA_W, default 8: shared-memory data width.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 core_req  input  NUM_CORES  per-core memory request; held high by the core until its val_data pulse.
REQ-007 core_we  input  NUM_CORES  per-core write enable (1 = store, 0 = load).
REQ-008 core_addr  input  NUM_CORES*ADDR_W  packed per-core addresses; core k occupies bits [k*ADDR_W +: ADDR_W].
REQ-009 core_wdata  input  NUM_CORES*DATA_W  packed per-core store data, using the same packing as core_addr.
REQ-010 core_rdata  output  DATA_W  load data broadcast to all cores; valid while the matching core_val_data bit is high.
REQ-011 core_val_data  output  NUM_CORES  one-hot completion pulse, one cycle wide, to the granted core.
REQ-012 mem_en  output  1  shared-memory access strobe.
REQ-013 mem_we  output  1  shared-memory write enable; meaningful only while mem_en is high.
REQ-014 mem_addr  output  ADDR_W  shared-memory address.
REQ-015 mem_wdata  output  DATA_W  shared-memory write data.
REQ-016 mem_rdata  input  DATA_W  shared-memory read data; valid exactly 1 cycle after mem_en with mem_we=0.
REQ-017 busy  output  1  high in every state other than IDLE.
REQ-018 grant_id  output  3  index of the core currently being served; holds its last value while in IDLE.

Function
REQ-019 The arbiter SHALL use four states: IDLE, ISSUE, WAIT, RELEASE. It SHALL serve exactly one transaction at a time.
REQ-020 IDLE: if any core_req bit is high, the arbiter SHALL grant the first requesting core found searching upward from rr_ptr, wrapping modulo NUM_CORES. On that edge it SHALL latch the granted core's index, we, addr and wdata, then go to ISSUE. If no bit is high, it stays in IDLE.
REQ-021 ISSUE: mem_en SHALL be high for exactly this one cycle, with mem_we, mem_addr and mem_wdata driven from the latched values. Next state is WAIT.
REQ-022 WAIT: for a load, core_rdata SHALL capture mem_rdata on the exiting edge. For a store, core_rdata SHALL keep its previous value.
REQ-023 WAIT: core_val_data[grant] SHALL be high for the cycle following WAIT. rr_ptr SHALL be set to (grant+1) mod NUM_CORES. Next state is RELEASE.
REQ-024 RELEASE: the arbiter SHALL stay until core_req[grant] is sampled low, then go to IDLE. This prevents a held request from being served twice.
REQ-025 Latency: core_req rising in IDLE at cycle 0 -> mem_en at cycle 1 -> core_val_data at cycle 3. Minimum spacing between grants is 4 cycles plus the RELEASE dwell.
REQ-026 Changes to the granted core's addr, wdata or we after the latch edge SHALL NOT affect the transaction in flight.
REQ-027 Deassertion of core_req[grant] before val_data SHALL NOT abort the transaction; the access and the val_data pulse still occur.
REQ-028 Requests arriving while busy SHALL be held by the requesters, not queued inside the arbiter. They are evaluated in the next IDLE cycle.
REQ-029 At most one core_val_data bit SHALL be high in any cycle. mem_en SHALL never be high outside ISSUE.
REQ-030 Fairness: with all cores requesting continuously, each core SHALL be granted once per NUM_CORES grants, in ascending cyclic order.

Reset
REQ-031 Asserting reset in any state SHALL immediately set: state=IDLE, rr_ptr=0, grant_id=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rdata=0, core_val_data=0, busy=0.
REQ-032 A transaction interrupted by reset SHALL be dropped, with no val_data pulse. After release, the first grant goes to the lowest-index requester.

Verification
REQ-033 Single load: core 2 requests addr 0x3A5, we=0, and memory returns 0x5C -> mem_en at cycle 1 with addr 0x3A5, core_val_data=4'b0100 and core_rdata=0x5C at cycle 3.
REQ-034 Store: core 0 requests addr 0x010, wdata 0xA7, we=1 -> one mem_en cycle with mem_we=1, mem_wdata=0xA7; core_val_data=4'b0001; core_rdata unchanged.
REQ-035 Round-robin: all four cores hold req, each dropping req for 1 cycle after its val_data -> grant order 0,1,2,3,0; no core_val_data overlap.
REQ-036 Held request: core 1 keeps req high for 5 cycles after its val_data -> no second grant to core 1 until req falls and rises again; core 3 requesting meanwhile is granted next.
REQ-037 Reset mid-WAIT: reset asserted during core 2's WAIT -> all outputs 0 asynchronously, no val_data pulse; after release, cores 1 and 3 requesting -> core 1 granted first.
REQ-038 Addr change after grant: core 3 changes addr from 0x100 to 0x200 one cycle after the latch edge -> mem_addr=0x100.
